dac_playback_ctrl: RTL and testbench



---
 rtl/dac_playback_ctrl.sv | 149 ++++++++++++++
 tb/tb_dac_playback_ctrl.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_playback_ctrl.sv
// Playback sequencer for the 10-bit DAC: sample FIFO, rate divider, IDLE/PRIME/RUN FSM and error flags.
// Optional circular-playback mode is compiled in with `define DAC_PLAYBACK_LOOP_EN (adds input loop).
module dac_playback_ctrl #(
  parameter int DW           = 10,
  parameter int FIFO_AW      = 4,
  parameter int CLKDIV_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [CLKDIV_WIDTH-1:0] clkdiv,
  input  logic                    wr,
  input  logic [DW-1:0]           w_data,
  input  logic                    flush,
  input  logic [FIFO_AW:0]        fifo_threshold,
  input  logic                    err_clr,
`ifdef DAC_PLAYBACK_LOOP_EN
  input  logic                    loop,
`endif
  output logic [FIFO_AW:0]        fifo_level,
  output logic                    fifo_full,
  output logic                    fifo_empty,
  output logic                    fifo_below,
  output logic [DW-1:0]           dac_data,
  output logic                    dac_load,
  output logic                    running,
  output logic                    underflow,
  output logic                    overflow
);

  localparam int DEPTH = 2**FIFO_AW;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN} state_t;

  state_t                  r_state;
  state_t                  w_next;
  logic                    w_run;
  logic                    w_tick;
  logic [CLKDIV_WIDTH-1:0] r_cnt;

  logic [DW-1:0]           r_mem [DEPTH];
  logic [FIFO_AW-1:0]      r_wp;
  logic [FIFO_AW-1:0]      r_rp;
  logic [FIFO_AW:0]        r_level;
  logic [DW-1:0]           r_dac;
  logic                    r_load;
  logic                    r_uf;
  logic                    r_of;

  logic                    w_full;
  logic                    w_empty;
  logic                    w_loop_act;
  logic                    w_pop;
  logic                    w_push;
  logic [DW-1:0]           w_push_data;
  logic                    w_uf_set;
  logic                    w_of_set;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (en) w_next = S_PRIME;
      S_PRIME: if (!en) w_next = S_IDLE;
               else if ((r_level >= fifo_threshold) || w_full) w_next = S_RUN;
      S_RUN:   if (!en) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_run  = (r_state == S_RUN);
    w_tick = w_run && (r_cnt == clkdiv);
  end

  // Divider only counts in RUN, so leaving RUN abandons any partial period.
  always_ff @(posedge clk) begin
    if (rst || !w_run || w_tick) r_cnt <= '0;
    else                         r_cnt <= r_cnt + 1'b1;
  end

`ifdef DAC_PLAYBACK_LOOP_EN
  assign w_loop_act = loop && w_run;
`else
  assign w_loop_act = 1'b0;
`endif

  assign w_full      = (r_level == DEPTH_L);
  assign w_empty     = (r_level == '0);
  assign w_pop       = w_tick && !w_empty && !flush;
  // In loop mode the popped head is recycled to the tail and external writes are locked out.
  assign w_push      = w_loop_act ? w_pop : (wr && !w_full && !flush);
  assign w_push_data = w_loop_act ? r_mem[r_rp] : w_data;
  assign w_uf_set    = w_tick && w_empty && !flush;
  assign w_of_set    = wr && w_full && !flush && !w_loop_act;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wp] <= w_push_data;
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      if (w_push && !w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop && !w_push) r_level <= r_level - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dac  <= {1'b1, {(DW-1){1'b0}}};
      r_load <= 1'b0;
    end else begin
      r_load <= w_pop;
      if (w_pop) r_dac <= r_mem[r_rp];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_uf <= 1'b0;
      r_of <= 1'b0;
    end else begin
      r_uf <= w_uf_set || (r_uf && !err_clr);
      r_of <= w_of_set || (r_of && !err_clr);
    end
  end

  assign fifo_level = r_level;
  assign fifo_full  = w_full;
  assign fifo_empty = w_empty;
  assign fifo_below = (r_level < fifo_threshold);
  assign dac_data   = r_dac;
  assign dac_load   = r_load;
  assign running    = w_run;
  assign underflow  = r_uf;
  assign overflow   = r_of;

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Self-checking bench for dac_playback_ctrl: directed vector table, corner sequences, random vs queue model.
module tb_dac_playback_ctrl;
  localparam int DW = 10, AW = 4, CW = 8, DEPTH = 16;

  logic clk = 1'b0;
  logic rst, en, wr, flush, err_clr;
  logic [CW-1:0] clkdiv;
  logic [DW-1:0] w_data;
  logic [AW:0]   thr;
  logic [AW:0]   fifo_level;
  logic          fifo_full, fifo_empty, fifo_below, dac_load, running, underflow, overflow;
  logic [DW-1:0] dac_data;
`ifdef DAC_PLAYBACK_LOOP_EN
  logic loop;
`endif

  always #5 clk = ~clk;

  dac_playback_ctrl #(.DW(DW), .FIFO_AW(AW), .CLKDIV_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .clkdiv(clkdiv), .wr(wr), .w_data(w_data),
    .flush(flush), .fifo_threshold(thr), .err_clr(err_clr),
`ifdef DAC_PLAYBACK_LOOP_EN
    .loop(loop),
`endif
    .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_below(fifo_below), .dac_data(dac_data), .dac_load(dac_load),
    .running(running), .underflow(underflow), .overflow(overflow)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Behavioural model: FIFO as a queue, sample period as a countdown of clk cycles.
  int m_q[$];
  int m_cnt, m_st, m_data;
  bit m_load, m_uf, m_of;

  task automatic model_step();
    int  lvl, nst, h;
    bit  full, empty, run, tick, pop, lp;
    lp = 1'b0;
`ifdef DAC_PLAYBACK_LOOP_EN
    lp = loop;
`endif
    if (rst) begin
      m_q.delete();
      m_cnt = 0; m_st = 0; m_data = 'h200; m_load = 0; m_uf = 0; m_of = 0;
      return;
    end
    lvl   = m_q.size();
    full  = (lvl == DEPTH);
    empty = (lvl == 0);
    run   = (m_st == 2);
    lp    = lp && run;
    tick  = run && (m_cnt == int'(clkdiv));
    pop   = tick && !empty && !flush;
    nst = m_st;
    if (m_st == 0 && en) nst = 1;
    else if (m_st == 1 && !en) nst = 0;
    else if (m_st == 1 && (lvl >= int'(thr) || full)) nst = 2;
    else if (m_st == 2 && !en) nst = 0;
    m_cnt = (run && !tick) ? m_cnt + 1 : 0;
    m_uf = (tick && empty && !flush) || (m_uf && !err_clr);
    m_of = (wr && full && !flush && !lp) || (m_of && !err_clr);
    m_load = pop;
    if (flush) m_q.delete();
    else begin
      if (pop) begin
        h = m_q.pop_front();
        m_data = h;
        if (lp) m_q.push_back(h);
      end
      if (wr && !full && !lp) m_q.push_back(int'(w_data));
    end
    m_st = nst;
  endtask

  task automatic compare_model();
    chk("rnd_level",   32'(fifo_level), 32'(m_q.size()));
    chk("rnd_full",    32'(fifo_full),  32'(m_q.size() == DEPTH));
    chk("rnd_empty",   32'(fifo_empty), 32'(m_q.size() == 0));
    chk("rnd_below",   32'(fifo_below), 32'(m_q.size() < int'(thr)));
    chk("rnd_dac",     32'(dac_data),   32'(m_data));
    chk("rnd_load",    32'(dac_load),   32'(m_load));
    chk("rnd_running", 32'(running),    32'(m_st == 2));
    chk("rnd_uf",      32'(underflow),  32'(m_uf));
    chk("rnd_of",      32'(overflow),   32'(m_of));
  endtask

  typedef struct {
    bit rst, en, wr, ec;
    logic [DW-1:0] wd;
    int lvl;
    bit ld;
    logic [DW-1:0] dat;
    bit run, uf;
  } vec_t;

  function automatic vec_t mk(bit r, bit e, bit w, bit c, int wd, int lvl, bit ld, int dat, bit run, bit uf);
    vec_t v;
    v.rst = r; v.en = e; v.wr = w; v.ec = c; v.wd = DW'(wd);
    v.lvl = lvl; v.ld = ld; v.dat = DW'(dat); v.run = run; v.uf = uf;
    return v;
  endfunction

  initial begin
    vec_t tv[$];
    int   words[$];
    int   got[$];
    int   nload;
    bit   done;
    int   wr_pct;

    rst = 1'b1; en = 1'b0; wr = 1'b0; flush = 1'b0; err_clr = 1'b0;
    clkdiv = 8'd3; w_data = '0; thr = 5'd3;
`ifdef DAC_PLAYBACK_LOOP_EN
    loop = 1'b0;
`endif

    // Reset, 3-word prime at threshold 3, period 4, then underflow and err_clr.
    tv.push_back(mk(1,0,0,0,0,     0,0,'h200,0,0));
    tv.push_back(mk(0,0,1,0,'h001, 1,0,'h200,0,0));
    tv.push_back(mk(0,0,1,0,'h002, 2,0,'h200,0,0));
    tv.push_back(mk(0,1,1,0,'h003, 3,0,'h200,0,0));
    tv.push_back(mk(0,1,0,0,0,     3,0,'h200,1,0));
    for (int i = 0; i < 3; i++) tv.push_back(mk(0,1,0,0,0, 3,0,'h200,1,0));
    tv.push_back(mk(0,1,0,0,0,     2,1,'h001,1,0));
    for (int i = 0; i < 3; i++) tv.push_back(mk(0,1,0,0,0, 2,0,'h001,1,0));
    tv.push_back(mk(0,1,0,0,0,     1,1,'h002,1,0));
    for (int i = 0; i < 3; i++) tv.push_back(mk(0,1,0,0,0, 1,0,'h002,1,0));
    tv.push_back(mk(0,1,0,0,0,     0,1,'h003,1,0));
    for (int i = 0; i < 3; i++) tv.push_back(mk(0,1,0,0,0, 0,0,'h003,1,0));
    tv.push_back(mk(0,1,0,0,0,     0,0,'h003,1,1));
    tv.push_back(mk(0,1,0,1,0,     0,0,'h003,1,0));
    tv.push_back(mk(0,0,0,0,0,     0,0,'h003,0,0));

    for (int i = 0; i < tv.size(); i++) begin
      rst = tv[i].rst; en = tv[i].en; wr = tv[i].wr; err_clr = tv[i].ec; w_data = tv[i].wd;
      step();
      chk($sformatf("tv%0d_level", i), 32'(fifo_level), 32'(tv[i].lvl));
      chk($sformatf("tv%0d_empty", i), 32'(fifo_empty), 32'(tv[i].lvl == 0));
      chk($sformatf("tv%0d_below", i), 32'(fifo_below), 32'(tv[i].lvl < 3));
      chk($sformatf("tv%0d_load", i),  32'(dac_load),   32'(tv[i].ld));
      chk($sformatf("tv%0d_data", i),  32'(dac_data),   32'(tv[i].dat));
      chk($sformatf("tv%0d_run", i),   32'(running),    32'(tv[i].run));
      chk($sformatf("tv%0d_uf", i),    32'(underflow),  32'(tv[i].uf));
      chk($sformatf("tv%0d_of", i),    32'(overflow),   32'h0);
      chk($sformatf("tv%0d_full", i),  32'(fifo_full),  32'h0);
    end
    err_clr = 1'b0; wr = 1'b0;

    // 17 writes while idle: 16 kept, 17th dropped with overflow.
    rst = 1'b1; step(); rst = 1'b0;
    clkdiv = 8'd0; thr = 5'd16;
    words.delete();
    for (int i = 0; i < 17; i++) begin
      words.push_back((i * 37 + 5) & 'h3FF);
      wr = 1'b1; w_data = DW'(words[i]); step();
    end
    wr = 1'b0;
    chk("ovf_full",  32'(fifo_full),  32'h1);
    chk("ovf_level", 32'(fifo_level), 32'd16);
    chk("ovf_flag",  32'(overflow),   32'h1);
    en = 1'b1;
    got.delete();
    for (int c = 0; c < 60; c++) begin
      step();
      if (dac_load) got.push_back(int'(dac_data));
    end
    chk("ovf_count", 32'(got.size()), 32'd16);
    for (int i = 0; i < got.size() && i < 16; i++)
      chk($sformatf("ovf_word%0d", i), 32'(got[i]), 32'(words[i]));
    chk("ovf_uf_after_drain", 32'(underflow), 32'h1);
    en = 1'b0; step();

    // Full FIFO at period 1, en dropped so exactly 5 samples play, then flush.
    rst = 1'b1; step(); rst = 1'b0;
    words.delete();
    for (int i = 0; i < 16; i++) begin
      words.push_back('h200 + i * 3);
      wr = 1'b1; w_data = DW'(words[i]); step();
    end
    wr = 1'b0; en = 1'b1; nload = 0; done = 1'b0;
    for (int c = 0; c < 60 && !done; c++) begin
      step();
      if (dac_load) nload++;
      if (nload == 4) begin
        en = 1'b0;
        step();
        done = 1'b1;
      end
    end
    if (!done) chk("stop_timeout", 32'h0, 32'h1);
    chk("stop_load5",   32'(dac_load),   32'h1);
    chk("stop_running", 32'(running),    32'h0);
    chk("stop_data",    32'(dac_data),   32'(words[4]));
    chk("stop_level",   32'(fifo_level), 32'd11);
    step();
    chk("stop_hold",    32'(dac_data),   32'(words[4]));
    chk("stop_noload",  32'(dac_load),   32'h0);
    chk("stop_level2",  32'(fifo_level), 32'd11);
    flush = 1'b1; step(); flush = 1'b0;
    chk("flush_level",  32'(fifo_level), 32'd0);
    chk("flush_empty",  32'(fifo_empty), 32'h1);
    chk("flush_uf",     32'(underflow),  32'h0);

`ifdef DAC_PLAYBACK_LOOP_EN
    // Circular playback of 4 words; an external write during RUN must be ignored.
    rst = 1'b1; step(); rst = 1'b0;
    words.delete();
    words.push_back('h0A1); words.push_back('h0B2); words.push_back('h0C3); words.push_back('h0D4);
    for (int i = 0; i < 4; i++) begin
      wr = 1'b1; w_data = DW'(words[i]); step();
    end
    wr = 1'b0; loop = 1'b1; clkdiv = 8'd1; thr = 5'd4; en = 1'b1; nload = 0;
    for (int c = 0; c < 100 && nload < 10; c++) begin
      wr = (nload == 3) && running;
      w_data = 10'h3FF;
      step();
      chk("loop_level", 32'(fifo_level), 32'd4);
      if (dac_load) begin
        chk($sformatf("loop_word%0d", nload), 32'(dac_data), 32'(words[nload % 4]));
        nload++;
      end
    end
    wr = 1'b0;
    chk("loop_count", 32'(nload), 32'd10);
    chk("loop_of",    32'(overflow), 32'h0);
    en = 1'b0; loop = 1'b0; step();
`endif

    // Randomised run against the queue model.
    rst = 1'b1; model_step(); step(); compare_model(); rst = 1'b0;
    en = 1'b1; clkdiv = 8'd1; thr = 5'd4; wr_pct = 50;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) wr_pct = ($urandom_range(0, 2) == 0) ? 20 : (($urandom_range(0, 1) == 0) ? 50 : 85);
      if (c % 64 == 0) clkdiv = CW'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) thr = (AW+1)'($urandom_range(0, 16));
      if ($urandom_range(0, 39) == 0) en = ~en;
      rst     = ($urandom_range(0, 399) == 0);
      flush   = ($urandom_range(0, 99) == 0);
      wr      = !flush && ($urandom_range(0, 99) < wr_pct);
      w_data  = DW'($urandom);
      err_clr = ($urandom_range(0, 24) == 0);
`ifdef DAC_PLAYBACK_LOOP_EN
      if ($urandom_range(0, 99) == 0) loop = ~loop;
`endif
      model_step();
      step();
      compare_model();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
